// File: rtl/ibex_multdiv_pkg.sv
// Shared types for the iterative multiplier/divider: operator encoding,
// FSM states and the iteration counter width helper.
package ibex_multdiv_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_COMP,
    MD_FIXUP,
    MD_DONE
  } md_iter_state_e;

  function automatic int unsigned md_cnt_width(input int unsigned width);
    return (width > 32'd1) ? $clog2(width) : 32'd1;
  endfunction

endpackage

// File: rtl/ibex_multdiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module ibex_multdiv_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             num_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit keeps the compare exact when the remainder's MSB is set,
  // which happens for unsigned divisors at or above 2^(WIDTH-1).
  assign shifted  = {rem, num_msb};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative shift-add multiplier / restoring divider with request/response
// handshake, kill and optional early multiply termination.
import ibex_multdiv_pkg::*;

module ibex_multdiv_iter #(
  parameter int unsigned WIDTH          = 32,
  parameter bit          EARLY_MUL_EXIT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             kill_i,
  input  logic [1:0]       operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CNT_W = md_cnt_width(WIDTH);
  localparam int unsigned W2    = 2 * WIDTH;

  md_iter_state_e   state_q, state_d;
  md_op_e           op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [W2-1:0]    a_sh_q, a_sh_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;

  md_op_e           op_in;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             is_mul;
  logic             last_iter;
  logic [W2-1:0]    acc_add;
  logic [WIDTH-1:0] b_shr;
  logic [WIDTH-1:0] ds_rem_next;
  logic             ds_q_bit;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign op_in  = md_op_e'(operator_i);
  assign sign_a = signed_mode_i[0] & op_a_i[WIDTH-1];
  assign sign_b = signed_mode_i[1] & op_b_i[WIDTH-1];
  assign mag_a  = sign_a ? (~op_a_i + 1'b1) : op_a_i;
  assign mag_b  = sign_b ? (~op_b_i + 1'b1) : op_b_i;

  assign is_mul    = (op_q == MD_OP_MULL) || (op_q == MD_OP_MULH);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_add   = acc_q + (b_sh_q[0] ? a_sh_q : '0);
  assign b_shr     = b_sh_q >> 1;

  // In divide mode acc holds {remainder, quotient}, a_sh the shifting
  // dividend and b_sh the divisor magnitude.
  ibex_multdiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc_q[W2-1:WIDTH]),
    .num_msb  (a_sh_q[WIDTH-1]),
    .divisor  (b_sh_q),
    .rem_next (ds_rem_next),
    .q_bit    (ds_q_bit)
  );

  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_q ? (~acc_q[W2-1:WIDTH] + 1'b1) : acc_q[W2-1:WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    a_sh_d  = a_sh_q;
    acc_d   = acc_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;

    unique case (state_q)
      MD_IDLE: begin
        if (req_valid_i && !kill_i) begin
          op_d   = op_in;
          neg_d  = (op_in == MD_OP_REM) ? sign_a : (sign_a ^ sign_b);
          cnt_d  = '0;
          a_sh_d = {{WIDTH{1'b0}}, mag_a};
          b_sh_d = mag_b;
          acc_d  = '0;
          if (operator_i[1] && (op_b_i == '0)) begin
            state_d = MD_DONE;
            res_d   = (op_in == MD_OP_DIV) ? '1 : op_a_i;
          end else begin
            state_d = MD_COMP;
          end
        end
      end

      MD_COMP: begin
        if (kill_i) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          a_sh_d = a_sh_q << 1;
          if (is_mul) begin
            acc_d  = acc_add;
            b_sh_d = b_shr;
            if (last_iter || (EARLY_MUL_EXIT && (b_shr == '0))) begin
              state_d = MD_FIXUP;
            end
          end else begin
            acc_d = {ds_rem_next, acc_q[WIDTH-2:0], ds_q_bit};
            if (last_iter) begin
              state_d = MD_FIXUP;
            end
          end
        end
      end

      MD_FIXUP: begin
        if (kill_i) begin
          state_d = MD_IDLE;
        end else begin
          state_d = MD_DONE;
          unique case (op_q)
            MD_OP_MULL: res_d = prod_fix[WIDTH-1:0];
            MD_OP_MULH: res_d = prod_fix[W2-1:WIDTH];
            MD_OP_DIV:  res_d = quo_fix;
            default:    res_d = rem_fix;
          endcase
        end
      end

      MD_DONE: begin
        if (kill_i || resp_ready_i) begin
          state_d = MD_IDLE;
        end
      end

      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= MD_IDLE;
      op_q    <= MD_OP_MULL;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      a_sh_q  <= '0;
      acc_q   <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      a_sh_q  <= a_sh_d;
      acc_q   <= acc_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
    end
  end

  assign req_ready_o  = (state_q == MD_IDLE);
  assign resp_valid_o = (state_q == MD_DONE);
  assign result_o     = (state_q == MD_DONE) ? res_q : '0;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed bench for ibex_multdiv_iter: one instance without and one with
// early multiply exit, driven by the same stimulus.
module tb_ibex_multdiv_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        kill;
  logic [1:0]  oper;
  logic [1:0]  smode;
  logic [31:0] op_a, op_b;
  logic        resp_ready;

  logic        req_ready0, resp_valid0;
  logic [31:0] result0;
  logic        req_ready_e, resp_valid_e;
  logic [31:0] result_e;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat0;
    int          late;
  } vec_t;

  always #5 clk = ~clk;

  ibex_multdiv_iter #(.WIDTH(32), .EARLY_MUL_EXIT(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready0),
    .kill_i(kill), .operator_i(oper), .signed_mode_i(smode), .op_a_i(op_a),
    .op_b_i(op_b), .resp_valid_o(resp_valid0), .resp_ready_i(resp_ready),
    .result_o(result0)
  );

  ibex_multdiv_iter #(.WIDTH(32), .EARLY_MUL_EXIT(1'b1)) u_dut_e (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready_e),
    .kill_i(kill), .operator_i(oper), .signed_mode_i(smode), .op_a_i(op_a),
    .op_b_i(op_b), .resp_valid_o(resp_valid_e), .resp_ready_i(resp_ready),
    .result_o(result_e)
  );

  // Issues one request from IDLE, measures latency of both instances
  // (acceptance edge counts as T, first valid cycle as T+lat), then acks.
  task automatic run_op(input logic [1:0] op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r0, output logic [31:0] re,
                        output int lat0, output int late);
    int n;
    req_valid = 1'b1; oper = op; smode = sm; op_a = a; op_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0; lat0 = -1; late = -1;
    while (n < 100) begin
      if (late < 0 && resp_valid_e) late = n + 1;
      if (resp_valid0) begin
        lat0 = n + 1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    r0 = result0;
    re = result_e;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({req_ready0, resp_valid0, result0} !== {1'b1, 1'b0, 32'h0}) begin
      errs++;
      $display("FAIL reset: rdy=%b vld=%b res=%h expected rdy=1 vld=0 res=0", req_ready0, resp_valid0, result0);
    end
    vecs++;
    if ({req_ready_e, resp_valid_e, result_e} !== {1'b1, 1'b0, 32'h0}) begin
      errs++;
      $display("FAIL reset_e: rdy=%b vld=%b res=%h expected rdy=1 vld=0 res=0", req_ready_e, resp_valid_e, result_e);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    vec_t tbl[8];
    logic [31:0] r0, re;
    int l0, le;
    tbl[0] = '{2'd0, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 4};
    tbl[1] = '{2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 34};
    tbl[2] = '{2'd1, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 34};
    tbl[3] = '{2'd1, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34, 34};
    tbl[4] = '{2'd0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34, 34};
    tbl[5] = '{2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 34};
    tbl[6] = '{2'd0, 2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 34, 3};
    tbl[7] = '{2'd1, 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'hFFFF_FFFF, 34, 7};
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].sm, tbl[i].a, tbl[i].b, r0, re, l0, le);
      vecs++;
      if (r0 !== tbl[i].exp) begin
        errs++;
        $display("FAIL mul[%0d] result: got %h expected %h", i, r0, tbl[i].exp);
      end
      vecs++;
      if (re !== tbl[i].exp) begin
        errs++;
        $display("FAIL mul[%0d] result_early: got %h expected %h", i, re, tbl[i].exp);
      end
      vecs++;
      if (l0 != tbl[i].lat0) begin
        errs++;
        $display("FAIL mul[%0d] latency: got T+%0d expected T+%0d", i, l0, tbl[i].lat0);
      end
      vecs++;
      if (le != tbl[i].late) begin
        errs++;
        $display("FAIL mul[%0d] latency_early: got T+%0d expected T+%0d", i, le, tbl[i].late);
      end
    end
  endtask

  task automatic test_div();
    vec_t tbl[12];
    logic [31:0] r0, re;
    int l0, le;
    tbl[0]  = '{2'd2, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 34};
    tbl[1]  = '{2'd3, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 34};
    tbl[2]  = '{2'd2, 2'b00, 32'd100,       32'd7,         32'd14,        34, 34};
    tbl[3]  = '{2'd3, 2'b00, 32'd100,       32'd7,         32'd2,         34, 34};
    tbl[4]  = '{2'd2, 2'b00, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1};
    tbl[5]  = '{2'd3, 2'b00, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1, 1};
    tbl[6]  = '{2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 34};
    tbl[7]  = '{2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 34};
    tbl[8]  = '{2'd2, 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 34, 34};
    tbl[9]  = '{2'd3, 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34, 34};
    tbl[10] = '{2'd3, 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34, 34};
    tbl[11] = '{2'd3, 2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1, 1};
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].sm, tbl[i].a, tbl[i].b, r0, re, l0, le);
      vecs++;
      if (r0 !== tbl[i].exp) begin
        errs++;
        $display("FAIL div[%0d] result: got %h expected %h", i, r0, tbl[i].exp);
      end
      vecs++;
      if (re !== tbl[i].exp) begin
        errs++;
        $display("FAIL div[%0d] result_early: got %h expected %h", i, re, tbl[i].exp);
      end
      vecs++;
      if (l0 != tbl[i].lat0) begin
        errs++;
        $display("FAIL div[%0d] latency: got T+%0d expected T+%0d", i, l0, tbl[i].lat0);
      end
      vecs++;
      if (le != tbl[i].late) begin
        errs++;
        $display("FAIL div[%0d] latency_early: got T+%0d expected T+%0d", i, le, tbl[i].late);
      end
    end
  endtask

  task automatic test_hold();
    int n;
    req_valid = 1'b1; oper = 2'd2; smode = 2'b00; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      vecs++;
      if ({resp_valid0, req_ready0, result0} !== {1'b1, 1'b0, 32'd14}) begin
        errs++;
        $display("FAIL hold[%0d]: vld=%b rdy=%b res=%h expected vld=1 rdy=0 res=0000000e", c, resp_valid0, req_ready0, result0);
      end
      vecs++;
      if ({resp_valid_e, result_e} !== {1'b1, 32'd14}) begin
        errs++;
        $display("FAIL hold_e[%0d]: vld=%b res=%h expected vld=1 res=0000000e", c, resp_valid_e, result_e);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    vecs++;
    if ({req_ready0, resp_valid0, result0} !== {1'b1, 1'b0, 32'h0}) begin
      errs++;
      $display("FAIL hold_release: rdy=%b vld=%b res=%h expected rdy=1 vld=0 res=0", req_ready0, resp_valid0, result0);
    end
  endtask

  task automatic test_kill();
    logic [31:0] r0, re;
    int l0, le;
    int seen;
    // Kill while IDLE must block acceptance.
    req_valid = 1'b1; kill = 1'b1; oper = 2'd0; smode = 2'b00; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0; kill = 1'b0;
    vecs++;
    if ({req_ready0, req_ready_e} !== 2'b11) begin
      errs++;
      $display("FAIL kill_idle: rdy=%b/%b expected 1/1", req_ready0, req_ready_e);
    end
    // Kill during the tenth COMP cycle of a divide.
    req_valid = 1'b1; oper = 2'd2; smode = 2'b00; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    vecs++;
    if ({req_ready0, resp_valid0, result0, req_ready_e, resp_valid_e} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL kill_comp: rdy=%b vld=%b res=%h rdy_e=%b vld_e=%b expected 1 0 0 1 0", req_ready0, resp_valid0, result0, req_ready_e, resp_valid_e);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid0 || resp_valid_e) seen++;
    end
    vecs++;
    if (seen != 0) begin
      errs++;
      $display("FAIL kill_no_resp: valid cycles=%0d expected 0", seen);
    end
    run_op(2'd2, 2'b00, 32'd100, 32'd7, r0, re, l0, le);
    vecs++;
    if (r0 !== 32'd14 || l0 != 34) begin
      errs++;
      $display("FAIL kill_next_op: res=%h lat=T+%0d expected 0000000e T+34", r0, l0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r0, re;
    int l0, le;
    req_valid = 1'b1; oper = 2'd1; smode = 2'b00; op_a = 32'hDEAD_BEEF; op_b = 32'hFFFF_0001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if ({req_ready0, resp_valid0, result0, req_ready_e, resp_valid_e, result_e} !==
        {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0}) begin
      errs++;
      $display("FAIL reset_mid: rdy=%b vld=%b res=%h rdy_e=%b vld_e=%b res_e=%h expected 1 0 0 1 0 0",
               req_ready0, resp_valid0, result0, req_ready_e, resp_valid_e, result_e);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'd0, 2'b11, 32'd6, 32'd7, r0, re, l0, le);
    vecs++;
    if (r0 !== 32'd42 || re !== 32'd42) begin
      errs++;
      $display("FAIL reset_next_op: res=%h res_e=%h expected 0000002a", r0, re);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; kill = 1'b0; oper = 2'd0; smode = 2'b00;
    op_a = '0; op_b = '0; resp_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_hold();
    test_kill();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
